// File: rtl/instr_encoder.sv
// Packs opcode/register/funct/immediate fields into RISC-V instruction words and streams them,
// with auto-incrementing byte addresses, toward instruction memory through a one-entry output slot.
module instr_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MAX_WORDS = 256,
   localparam int         CW        = $clog2(MAX_WORDS + 1)
) (
   input  logic          iCLK,
   input  logic          iRST,
   input  logic          iClear,
   input  logic          iValid,
   output logic          oReady,
   input  logic [6:0]    iOpcode,
   input  logic [4:0]    iRd,
   input  logic [4:0]    iRs1,
   input  logic [4:0]    iRs2,
   input  logic [2:0]    iFunct3,
   input  logic [6:0]    iFunct7,
   input  logic [31:0]   iImm,
   output logic          oValid,
   input  logic          iReady,
   output logic [31:0]   oInstr,
   output logic [31:0]   oAddr,
   output logic [CW-1:0] oCount,
   output logic          oFull,
   output logic          oError,
   output logic [1:0]    oErrCode
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_TIPOI  = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JUMP   = 7'b1101111;
   localparam logic [6:0] OP_TIPOR  = 7'b0110011;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_OPCODE   = 2'b01;
   localparam logic [1:0] ERR_RANGE    = 2'b10;
   localparam logic [1:0] ERR_MISALIGN = 2'b11;

   logic [31:0] enc_word;
   logic        op_ok;
   logic        misalign;
   logic        range_bad;
   logic [1:0]  req_err;
   logic [31:0] addr_cnt;
   logic        take;

   // Sign-extension check: upper immediate bits must all replicate the format's sign bit.
   logic fits_12, fits_13, fits_21;
   assign fits_12 = (&iImm[31:11]) | ~(|iImm[31:11]);
   assign fits_13 = (&iImm[31:12]) | ~(|iImm[31:12]);
   assign fits_21 = (&iImm[31:20]) | ~(|iImm[31:20]);

   always_comb begin
      enc_word  = 32'h0;
      op_ok     = 1'b1;
      misalign  = 1'b0;
      range_bad = 1'b0;
      case (iOpcode)
         OP_LOAD, OP_TIPOI: begin
            enc_word  = {iImm[11:0], iRs1, iFunct3, iRd, iOpcode};
            range_bad = !fits_12;
         end
         OP_STORE: begin
            enc_word  = {iImm[11:5], iRs2, iRs1, iFunct3, iImm[4:0], iOpcode};
            range_bad = !fits_12;
         end
         OP_BRANCH: begin
            enc_word  = {iImm[12], iImm[10:5], iRs2, iRs1, iFunct3, iImm[4:1], iImm[11], iOpcode};
            range_bad = !fits_13;
            misalign  = iImm[0];
         end
         OP_JUMP: begin
            enc_word  = {iImm[20], iImm[10:1], iImm[11], iImm[19:12], iRd, iOpcode};
            range_bad = !fits_21;
            misalign  = iImm[0];
         end
         OP_TIPOR: begin
            enc_word  = {iFunct7, iRs2, iRs1, iFunct3, iRd, iOpcode};
         end
         default: begin
            op_ok     = 1'b0;
         end
      endcase
   end

   always_comb begin
      req_err = ERR_NONE;
      if (!op_ok)
         req_err = ERR_OPCODE;
      else if (misalign)
         req_err = ERR_MISALIGN;
      else if (range_bad)
         req_err = ERR_RANGE;
   end

   assign oFull  = (oCount == CW'(MAX_WORDS));
   assign oReady = !oFull && (!oValid || iReady);
   // A request coinciding with iClear is swallowed: the clear wins that edge.
   assign take   = iValid && oReady && !iClear;

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         oValid   <= 1'b0;
         oInstr   <= 32'h0;
         oAddr    <= BASE_ADDR;
         oCount   <= '0;
         oError   <= 1'b0;
         oErrCode <= ERR_NONE;
         addr_cnt <= BASE_ADDR;
      end else begin
         if (oValid && iReady)
            oValid <= 1'b0;
         if (iClear) begin
            addr_cnt <= BASE_ADDR;
            oCount   <= '0;
            oError   <= 1'b0;
            oErrCode <= ERR_NONE;
         end else if (take) begin
            if (req_err != ERR_NONE) begin
               oError <= 1'b1;
               if (!oError)
                  oErrCode <= req_err;
            end else begin
               oValid   <= 1'b1;
               oInstr   <= enc_word;
               oAddr    <= addr_cnt;
               addr_cnt <= addr_cnt + 32'd4;
               oCount   <= oCount + CW'(1);
            end
         end
      end
   end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the immediate generator: packs opcode, register fields, funct fields and a 32-bit signed immediate into a RISC-V instruction word.
- Validates the immediate against the target format and writes each accepted word, with an auto-incrementing address, toward instruction memory.
- Used by the boot/program loader and by the testbench program builder.
- Valid/ready handshake on both sides with a one-entry registered output.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address assigned to the first emitted word after reset or iClear.
- MAX_WORDS, 256, capacity of the target instruction memory in words; emission stops when reached.

Ports:
- iCLK  in  1  clock
- iRST  in  1  reset, asynchronous, active-high
- iClear  in  1  synchronous: reload address to BASE_ADDR, zero count, clear error
- iValid  in  1  request fields valid
- oReady  out  1  encoder can accept request this cycle
- iOpcode  in  7  LOAD 0000011, TIPOI 0010011, STORE 0100011, BRANCH 1100011, JUMP 1101111, TIPOR 0110011
- iRd  in  5  destination register
- iRs1  in  5  source register 1
- iRs2  in  5  source register 2
- iFunct3  in  3  funct3
- iFunct7  in  7  funct7 (TIPOR only)
- iImm  in  32  signed immediate/offset (ignored for TIPOR)
- oValid  out  1  oInstr/oAddr valid
- iReady  in  1  memory consumes output
- oInstr  out  32  encoded instruction
- oAddr  out  32  byte address for oInstr
- oCount  out  clog2(MAX_WORDS+1)  words accepted since reset/iClear
- oFull  out  1  oCount == MAX_WORDS
- oError  out  1  sticky error flag
- oErrCode  out  2  code of first error: 01 bad opcode, 10 imm out of range, 11 misaligned offset

Behaviour:
- Reset (async): oValid=0, oInstr=0, oAddr=BASE_ADDR, oCount=0, oFull=0, oError=0, oErrCode=0. Reset mid-transfer drops the held word.
- oReady = !oFull && (!oValid || iReady), combinational.
- Accept on a rising edge with iValid && oReady. Latency is 1 cycle: oInstr, oAddr and oValid update on that edge.
- Output drain: with oValid && iReady and no new accept, oValid clears on the edge. Simultaneous drain and accept keeps oValid=1 with the new word (back-to-back, full throughput).
- Output stability: while oValid && !iReady, oInstr and oAddr hold stable.
- Address and count: each successful accept uses the current address counter as oAddr, then advances the counter by 4 and oCount by 1. oFull is asserted when oCount reaches MAX_WORDS. No wrap; further requests stall via oReady=0.
- Encoding:
  - LOAD, TIPOI: {imm[11:0], rs1, f3, rd, op}
  - STORE: {imm[11:5], rs2, rs1, f3, imm[4:0], op}
  - BRANCH: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}
  - JUMP: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}
  - TIPOR: {f7, rs2, rs1, f3, rd, op}
- Range checks:
  - I/S: iImm[31:11] all equal.
  - B: iImm[31:12] all equal.
  - J: iImm[31:20] all equal.
  - Misaligned: B/J with iImm[0]=1.
- Error priority: bad opcode > misaligned > range.
- Errored request:
  - It is consumed (handshake completes) but not emitted: no oValid, no address or count advance.
  - oError sets on the next edge; oErrCode latches only if oError was 0 (first error sticks).
  - Output register and drain are unaffected.
- iClear: sync, highest priority over accept on that edge. It reloads address/count and clears oError/oErrCode and oFull, but does not drop a held oValid word.
- Round-trip invariant: for accepted non-TIPOR words, the immediate generator applied to oInstr returns iImm; decoded rd/rs1/rs2/f3 fields equal the inputs.

Test Plan:
- addi x1,x0,5 (TIPOI, rd=1, imm=5), iReady=1 -> next cycle oValid=1, oInstr=32'h00500093, oAddr=0, oCount=1.
- sw x2,8(x1) then beq x0,x0,-4 then jal x1,8, issued back-to-back -> 32'h0020A423 @0, 32'hFE000EE3 @4, 32'h008000EF @8; one word per cycle, oReady stays 1.
- Backpressure: iReady=0 for 5 cycles with a second request pending -> oInstr/oAddr stable, oReady=0, second word emitted the cycle after iReady=1, no loss or duplication.
- Errors: TIPOI imm=2048 -> oError=1, oErrCode=10, no oValid, oCount unchanged. Then BRANCH imm=3 -> oErrCode stays 10. Then iClear -> oError=0.
- Capacity: MAX_WORDS=4, issue 5 valid requests -> 4 emitted (addrs 0,4,8,12), oFull=1, oReady=0. iClear -> oReady=1, next word at BASE_ADDR.
- Assert iRST while oValid=1 and iReady=0 -> all outputs at reset values immediately, without waiting for an iCLK edge.
